// File: rtl/csa_resolve20.sv
// Iterative carry-propagate resolver for a 20-bit carry-save pair: result = sum + 2*cout,
// CHUNK bits per cycle. Optional overflow flag enabled by defining CSA_RESOLVE_OVF_EN.
module csa_resolve20 #(
  parameter int unsigned CHUNK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [19:0] sum,
  input  logic [19:0] cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [21:0] result,
  output logic        ovf
);

  localparam int unsigned N = 24 / CHUNK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLast = KW'(N - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          r_state, w_state_nx;
  logic [23:0]     r_a, r_b, r_acc;
  logic [KW-1:0]   r_k;
  logic            r_c;
  logic [21:0]     r_result;

  logic [4:0]       w_lo;
  logic [CHUNK-1:0] w_a_ch, w_b_ch, w_r;
  logic [CHUNK:0]   w_sum_ch;
  logic             w_c_nx;
  logic [23:0]      w_acc_nx;
  logic             w_last;

  assign w_lo     = 5'(32'(r_k) * CHUNK);
  assign w_a_ch   = r_a[w_lo +: CHUNK];
  assign w_b_ch   = r_b[w_lo +: CHUNK];
  assign w_sum_ch = {1'b0, w_a_ch} + {1'b0, w_b_ch} + {{CHUNK{1'b0}}, r_c};
  assign w_r      = w_sum_ch[CHUNK-1:0];
  assign w_c_nx   = w_sum_ch[CHUNK];
  assign w_last   = (r_k == KLast);

  always_comb begin
    w_acc_nx = r_acc;
    w_acc_nx[w_lo +: CHUNK] = w_r;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      StIdle:  if (in_valid) w_state_nx = StBusy;
      StBusy:  if (w_last) w_state_nx = StDone;
      StDone:  if (out_ready) w_state_nx = StIdle;
      default: w_state_nx = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_k      <= '0;
      r_c      <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nx;
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a <= {4'b0, sum};
            r_b <= {3'b0, cout, 1'b0};
            r_k <= '0;
            r_c <= 1'b0;
          end
        end
        StBusy: begin
          r_acc <= w_acc_nx;
          // Final chunk carry is always zero (max result 0x2FFFFD), so it is simply dropped.
          r_c   <= w_c_nx;
          if (w_last) r_result <= w_acc_nx[21:0];
          else        r_k      <= r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign result    = r_result;

`ifdef CSA_RESOLVE_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == StBusy && w_last) begin
      r_ovf <= |w_acc_nx[21:20];
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_csa_resolve20.sv
// Self-checking bench for csa_resolve20: vector table plus latency, backpressure and reset cases.
module tb_csa_resolve20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [19:0] s_sum = '0;
  logic [19:0] s_cout = '0;

  logic        in_ready, out_valid, ovf;
  logic [21:0] result;
  logic        in_ready_c1, out_valid_c1, ovf_c1;
  logic [21:0] result_c1;
  logic        in_ready_c24, out_valid_c24, ovf_c24;
  logic [21:0] result_c24;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [19:0] s;
    logic [19:0] c;
    logic [21:0] r;
  } vec_t;

  typedef struct {
    logic [21:0] r;
    logic        o;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  csa_resolve20 #(.CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sum(s_sum),
    .cout(s_cout), .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf)
  );

  csa_resolve20 #(.CHUNK(1)) u_dut_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c1), .sum(s_sum),
    .cout(s_cout), .out_valid(out_valid_c1), .out_ready(out_ready), .result(result_c1),
    .ovf(ovf_c1)
  );

  csa_resolve20 #(.CHUNK(24)) u_dut_c24 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c24), .sum(s_sum),
    .cout(s_cout), .out_valid(out_valid_c24), .out_ready(out_ready), .result(result_c24),
    .ovf(ovf_c24)
  );

  function automatic logic exp_ovf(input logic [21:0] r);
`ifdef CSA_RESOLVE_OVF_EN
    return |r[21:20];
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one pair through the accept edge; expected value goes to the scoreboard.
  task automatic accept(input logic [19:0] s, input logic [19:0] c, input logic [21:0] r);
    exp_t e;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    s_sum    = s;
    s_cout   = c;
    in_valid = 1'b1;
    e.r = r;
    e.o = exp_ovf(r);
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int lat, input bit handoff);
    int   cyc = 0;
    exp_t e;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(lat));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("result", 32'(result), 32'(e.r));
      chk("ovf", 32'(ovf), 32'(e.o));
    end else begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end
    if (handoff) begin
      @(posedge clk);
      #1;
      chk("in_ready_after_handoff", 32'(in_ready), 32'd1);
      chk("out_valid_after_handoff", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    vec_t vecs[8];
    int   lat4, lat1, lat24;
    logic [21:0] r4, r1, r24;
    logic o4, o1, o24;
    bit   seen;

    vecs[0] = '{20'h00000, 20'h00000, 22'h000000};
    vecs[1] = '{20'h12345, 20'h00001, 22'h012347};
    vecs[2] = '{20'hFFFFF, 20'hFFFFF, 22'h2FFFFD};
    vecs[3] = '{20'h00001, 20'h7FFFF, 22'h0FFFFF};
    vecs[4] = '{20'h80000, 20'h80000, 22'h180000};
    vecs[5] = '{20'hAAAAA, 20'h55555, 22'h155554};
    vecs[6] = '{20'hFFFFF, 20'h00000, 22'h0FFFFF};
    vecs[7] = '{20'h00000, 20'h80000, 22'h100000};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);

    // Same operands into all three chunk widths, accepted on the same edge.
    lat4 = -1; lat1 = -1; lat24 = -1;
    r4 = '0; r1 = '0; r24 = '0; o4 = 0; o1 = 0; o24 = 0;
    accept(20'hFFFFF, 20'hFFFFF, 22'h2FFFFD);
    void'(sb.pop_front());
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid && lat4 < 0)      begin lat4  = cyc; r4  = result;     o4  = ovf;     end
      if (out_valid_c1 && lat1 < 0)   begin lat1  = cyc; r1  = result_c1;  o1  = ovf_c1;  end
      if (out_valid_c24 && lat24 < 0) begin lat24 = cyc; r24 = result_c24; o24 = ovf_c24; end
      @(posedge clk);
      #1;
    end
    chk("c4_latency", 32'(lat4), 32'd6);
    chk("c1_latency", 32'(lat1), 32'd24);
    chk("c24_latency", 32'(lat24), 32'd1);
    chk("c4_result", 32'(r4), 32'h2FFFFD);
    chk("c1_result", 32'(r1), 32'h2FFFFD);
    chk("c24_result", 32'(r24), 32'h2FFFFD);
    chk("c4_ovf", 32'(o4), 32'(exp_ovf(22'h2FFFFD)));
    chk("c1_ovf", 32'(o1), 32'(exp_ovf(22'h2FFFFD)));
    chk("c24_ovf", 32'(o24), 32'(exp_ovf(22'h2FFFFD)));

    foreach (vecs[i]) begin
      accept(vecs[i].s, vecs[i].c, vecs[i].r);
      wait_result(6, 1'b1);
    end

    // Backpressure: result held, new data offered but not captured until hand-off.
    out_ready = 1'b0;
    accept(20'h12345, 20'h00001, 22'h012347);
    wait_result(6, 1'b0);
    s_sum    = 20'h00010;
    s_cout   = 20'h00001;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_result_held", 32'(result), 32'h012347);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_out_valid_held", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_handoff_in_ready", 32'(in_ready), 32'd1);
    chk("bp_handoff_out_valid", 32'(out_valid), 32'd0);
    accept(20'h00010, 20'h00001, 22'h000012);
    wait_result(6, 1'b1);

    // Reset on the third BUSY cycle aborts with no output.
    accept(20'hFFFFF, 20'hFFFFF, 22'h2FFFFD);
    void'(sb.pop_front());
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || result != 22'd0) seen = 1'b1;
    end
    chk("abort_no_stale_output", 32'(seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_resolve20.md
# csa_resolve20

Sequential carry-propagate resolver for the 20-bit carry-save pair produced by the ALU's 3:2 compressor stage. It accepts a redundant `sum` / `cout` vector pair over a valid/ready handshake and computes the binary value `sum + (cout << 1)`. The addition is done iteratively, `CHUNK` bits per cycle, with the carry held in a register between chunks. The block sits between the carry-save accumulation tree and the ALU result register, and trades latency for a short carry chain.

## Interface
- `CHUNK`, default 4: bits resolved per cycle; legal values are 1, 2, 3, 4, 6, 8, 12, 24 (divisors of 24).
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `in_valid`  input  1  carry-save operand pair is valid.
- `in_ready`  output  1  block can accept an operand pair.
- `sum`  input  20  carry-save sum vector, bit i has weight 2^i.
- `cout`  input  20  carry-save carry vector, bit i has weight 2^(i+1).
- `out_valid`  output  1  `result` is valid.
- `out_ready`  input  1  downstream accepts `result`.
- `result`  output  22  resolved value `sum + 2*cout`.
- `ovf`  output  1  result exceeds 20 bits (see Configuration).

## Operation
- Internal operands are 24 bits wide: A = {4'b0, sum} and B = {3'b0, cout, 1'b0}.
- N = 24/CHUNK.
- States:
  - IDLE: `in_ready`=1.
  - BUSY: chunk index k runs 0..N-1; carry register c.
  - DONE: `out_valid`=1.
- IDLE: when `in_valid`=1, capture A and B, set k=0 and c=0, and go to BUSY.
- BUSY: each cycle computes {c', r} = A[k*CHUNK +: CHUNK] + B[k*CHUNK +: CHUNK] + c.
  - Write r into a 24-bit accumulator at the same slice and set c = c'.
  - If k==N-1, go to DONE; otherwise increment k.
- The carry out of the final chunk is discarded. It is provably 0, because the maximum result is 0x2FFFFD < 2^22.
- `result` = accumulator[21:0], registered.
- DONE: hold `result` and `ovf` stable while `out_ready`=0. When `out_ready`=1, go to IDLE and clear `out_valid`.
- `in_ready` is derived solely from state (IDLE). `in_valid` is ignored in BUSY and DONE, and captured operands are never overwritten mid-operation.
- Reset:
  - State goes to IDLE; k, c, accumulator, `result` and `ovf` clear to 0; `out_valid` goes to 0.
  - `in_ready` reads 1 in the cycle after the reset edge.
  - Reset asserted in any state, including mid-BUSY, aborts the operation with no output.

## Timing
- Accept edge T is the rising edge where state=IDLE and `in_valid`=1.
- Chunk k is resolved on edge T+1+k.
- `out_valid` rises after edge T+N: 6 cycles for CHUNK=4, 1 for CHUNK=24, 24 for CHUNK=1.
- Hand-off edge is the first edge with `out_valid`&&`out_ready`. `in_ready` is 1 in the following cycle.
- Minimum initiation interval is N+2 cycles, with no overlap between operations.
- `out_valid`, `result`, `ovf` and `in_ready` are all register-driven or state-decoded; there are no combinational paths from inputs to outputs.

## Configuration
- `CSA_RESOLVE_OVF_EN` defined: `ovf` is registered alongside `result` and equals (result[21:20] != 0). It is valid whenever `out_valid`=1 and clears on reset.
- `CSA_RESOLVE_OVF_EN` undefined: the port remains, `ovf` is tied to 0, and no overflow logic is generated.

## Test plan
- sum=0, cout=0, CHUNK=4 -> `out_valid` 6 cycles after accept, result=0x000000, ovf=0.
- sum=0x12345, cout=0x00001 -> result=0x012347, ovf=0.
- sum=0xFFFFF, cout=0xFFFFF with `CSA_RESOLVE_OVF_EN` defined -> result=0x2FFFFD, ovf=1. Without the macro -> result identical, ovf=0.
- Same operands as above at CHUNK=1 and CHUNK=24 -> identical result, `out_valid` after 24 and 1 cycles respectively.
- Backpressure: `out_ready`=0 for 5 cycles after `out_valid` while `in_valid`=1 with new data -> `result` held unchanged, `in_ready`=0, new data not captured. Raise `out_ready` -> IDLE, then the new pair is accepted.
- `rst` pulsed on the 3rd BUSY cycle -> next cycle is IDLE: `out_valid`=0, result=0, `in_ready`=1, and no stale result ever appears.
